// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Purpose  : Shared types for the five-stage pipeline: register index type
//            and the pipeline controller FSM state encoding.
// Ports    : none (package)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    // Register-file index width used across the datapath.
    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    // Pipeline-wide sequencer states: normal flow, data-memory wait,
    // halt drain and final stop.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } plctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_if
// Purpose  : Bundle of hazard/request inputs and strobe outputs between the
//            datapath and the pipeline controller.
// Ports    : master - controller side (drives wen/flush/halted)
//            slave  - datapath side (drives hit/request/hazard sources)
// Config   : PLCTRL_PERF_EN adds stall_cnt / flush_cnt (controller driven)
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if #(
    parameter int REGW = 5
);
    logic            ihit;
    logic            dhit;
    logic            exmem_memread;
    logic            exmem_memwrite;
    logic            idex_memread;
    logic [REGW-1:0] idex_rt;
    logic [REGW-1:0] ifid_rs;
    logic [REGW-1:0] ifid_rt;
    logic            branch_taken;
    logic            jump;
    logic            exmem_halt;

    logic            pc_wen;
    logic            ifid_wen;
    logic            idex_wen;
    logic            exmem_wen;
    logic            memwb_wen;
    logic            ifid_flush;
    logic            idex_flush;
    logic            exmem_flush;
    logic            memwb_flush;
    logic            halted;
`ifdef PLCTRL_PERF_EN
    logic [31:0]     stall_cnt;
    logic [31:0]     flush_cnt;
`endif

    modport master (
        input  ihit, dhit, exmem_memread, exmem_memwrite, idex_memread,
               idex_rt, ifid_rs, ifid_rt, branch_taken, jump, exmem_halt,
        output pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
               ifid_flush, idex_flush, exmem_flush, memwb_flush, halted
`ifdef PLCTRL_PERF_EN
       ,output stall_cnt, flush_cnt
`endif
    );

    modport slave (
        output ihit, dhit, exmem_memread, exmem_memwrite, idex_memread,
               idex_rt, ifid_rs, ifid_rt, branch_taken, jump, exmem_halt,
        input  pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
               ifid_flush, idex_flush, exmem_flush, memwb_flush, halted
`ifdef PLCTRL_PERF_EN
       ,input  stall_cnt, flush_cnt
`endif
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Purpose  : Combinational load-use hazard detection between the load in EX
//            and the source operands of the instruction in ID.
// Ports    : i_idex_memread, i_idex_rt - load in EX and its destination
//            i_ifid_rs, i_ifid_rt     - sources of the instruction in ID
//            o_hazard                 - stall request
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module hazard_detect #(
    parameter int REGW = 5
) (
    input  logic            i_idex_memread,
    input  logic [REGW-1:0] i_idex_rt,
    input  logic [REGW-1:0] i_ifid_rs,
    input  logic [REGW-1:0] i_ifid_rt,
    output logic            o_hazard
);
    // Register 0 is hard-wired to zero, so a load targeting it never
    // produces a value anyone could be waiting for.
    assign o_hazard = i_idex_memread && (i_idex_rt != '0) &&
                      ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));
endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Central sequencer for the five-stage pipeline. Produces the
//            write-enable and flush strobes of the PC and the four pipeline
//            registers, arbitrating memory stalls, load-use hazards, taken
//            branches, jumps and halt. Strobes are combinational from the
//            FSM state and the current inputs.
// Ports    : CLK  - clock, rising edge
//            RST  - asynchronous active-high reset
//            bus  - pipeline_ctrl_if.master (requests in, strobes out)
// Config   : PLCTRL_PERF_EN adds saturating stall_cnt / flush_cnt counters
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int REGW = 5
) (
    input  logic           CLK,
    input  logic           RST,
    pipeline_ctrl_if.master bus
);

    plctrl_state_t r_state;
    plctrl_state_t w_state_nxt;
    logic          w_hazard;
    logic          w_memop;
    logic          w_mem_stall;

    hazard_detect #(.REGW(REGW)) u_hazard_detect (
        .i_idex_memread (bus.idex_memread),
        .i_idex_rt      (bus.idex_rt),
        .i_ifid_rs      (bus.ifid_rs),
        .i_ifid_rt      (bus.ifid_rt),
        .o_hazard       (w_hazard)
    );

    assign w_memop = bus.exmem_memread | bus.exmem_memwrite;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        bus.pc_wen      = 1'b1;
        bus.ifid_wen    = 1'b1;
        bus.idex_wen    = 1'b1;
        bus.exmem_wen   = 1'b1;
        bus.memwb_wen   = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_flush  = 1'b0;
        bus.exmem_flush = 1'b0;
        bus.memwb_flush = 1'b0;
        bus.halted      = 1'b0;

        // Once in DWAIT the request is known to be outstanding, so only
        // dhit matters; from RUN a new request must be present.
        w_mem_stall = !bus.dhit &&
                      ((r_state == DWAIT) || ((r_state == RUN) && w_memop));

        case (r_state)
            HALTED: begin
                bus.pc_wen    = 1'b0;
                bus.ifid_wen  = 1'b0;
                bus.idex_wen  = 1'b0;
                bus.exmem_wen = 1'b0;
                bus.memwb_wen = 1'b0;
                bus.halted    = 1'b1;
            end
            DRAIN: begin
                // Let the halt retire through MEM/WB while squashing
                // everything younger.
                bus.pc_wen      = 1'b0;
                bus.ifid_flush  = 1'b1;
                bus.idex_flush  = 1'b1;
                bus.exmem_flush = 1'b1;
                w_state_nxt     = HALTED;
            end
            default: begin
                if (w_mem_stall) begin
                    // Freeze the whole pipe; a pending branch stays in
                    // EX/MEM because exmem_wen is low.
                    bus.pc_wen    = 1'b0;
                    bus.ifid_wen  = 1'b0;
                    bus.idex_wen  = 1'b0;
                    bus.exmem_wen = 1'b0;
                    bus.memwb_wen = 1'b0;
                    w_state_nxt   = DWAIT;
                end else begin
                    w_state_nxt = RUN;
                    if (bus.exmem_halt) begin
                        bus.pc_wen      = 1'b0;
                        bus.ifid_flush  = 1'b1;
                        bus.idex_flush  = 1'b1;
                        bus.exmem_flush = 1'b1;
                        w_state_nxt     = DRAIN;
                    end else if (bus.branch_taken) begin
                        bus.ifid_flush  = 1'b1;
                        bus.idex_flush  = 1'b1;
                        bus.exmem_flush = 1'b1;
                    end else if (w_hazard) begin
                        bus.pc_wen     = 1'b0;
                        bus.ifid_wen   = 1'b0;
                        bus.idex_flush = 1'b1;
                    end else if (bus.jump) begin
                        // Jump beats a missing fetch: the PC takes the target.
                        bus.ifid_flush = 1'b1;
                    end else if (!bus.ihit) begin
                        bus.pc_wen     = 1'b0;
                        bus.ifid_flush = 1'b1;
                    end
                end
            end
        endcase
    end

`ifdef PLCTRL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_any_flush;

    assign w_any_flush = bus.ifid_flush | bus.idex_flush |
                         bus.exmem_flush | bus.memwb_flush;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!bus.pc_wen && (r_state != HALTED) && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_any_flush && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Purpose  : Self-checking bench for pipeline_ctrl: directed scenarios with
//            literal expectations followed by randomized traffic checked
//            against a behavioural model every cycle.
// Config   : PLCTRL_PERF_EN also checks stall_cnt / flush_cnt
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;
    import cpu_types_pkg::*;

    // Output vector order: {pc,ifid,idex,exmem,memwb}_wen,
    // {ifid,idex,exmem,memwb}_flush, halted
    localparam logic [9:0] C_ALL_RUN  = 10'b11111_0000_0;
    localparam logic [9:0] C_FREEZE   = 10'b00000_0000_0;
    localparam logic [9:0] C_DRAIN    = 10'b01111_1110_0;
    localparam logic [9:0] C_HALTED   = 10'b00000_0000_1;
    localparam logic [9:0] C_BRANCH   = 10'b11111_1110_0;
    localparam logic [9:0] C_LOADUSE  = 10'b00111_0100_0;
    localparam logic [9:0] C_JUMP     = 10'b11111_1000_0;
    localparam logic [9:0] C_NOFETCH  = 10'b01111_1000_0;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    pipeline_ctrl_if #(.REGW(REG_W)) bus ();

    pipeline_ctrl #(.REGW(REG_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state: phase 0 = flowing, 1 = draining after halt,
    // 2 = stopped; m_wait = a data access is known to be outstanding.
    int          m_phase = 0;
    bit          m_wait  = 1'b0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_flush = '0;
    logic [9:0]  m_exp;
    logic [9:0]  dut_vec;

    function automatic logic [9:0] expect_vec(
        int phase, bit waiting, logic ihit, logic dhit, logic memop,
        logic ld, logic [REG_W-1:0] rt, logic [REG_W-1:0] rs1,
        logic [REG_W-1:0] rs2, logic br, logic jmp, logic hlt);
        bit haz;
        haz = ld && (rt != 0) && (rt == rs1 || rt == rs2);
        if (phase == 2)                  return C_HALTED;
        if (phase == 1)                  return C_DRAIN;
        if (!dhit && (waiting || memop)) return C_FREEZE;
        if (hlt)                         return C_DRAIN;
        if (br)                          return C_BRANCH;
        if (haz)                         return C_LOADUSE;
        if (jmp)                         return C_JUMP;
        if (!ihit)                       return C_NOFETCH;
        return C_ALL_RUN;
    endfunction

    assign m_exp = expect_vec(m_phase, m_wait, bus.ihit, bus.dhit,
                              bus.exmem_memread | bus.exmem_memwrite,
                              bus.idex_memread, bus.idex_rt, bus.ifid_rs,
                              bus.ifid_rt, bus.branch_taken, bus.jump,
                              bus.exmem_halt);

    assign dut_vec = {bus.pc_wen, bus.ifid_wen, bus.idex_wen, bus.exmem_wen,
                      bus.memwb_wen, bus.ifid_flush, bus.idex_flush,
                      bus.exmem_flush, bus.memwb_flush, bus.halted};

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_phase <= 0;
            m_wait  <= 1'b0;
            m_stall <= '0;
            m_flush <= '0;
        end else begin
            if (!m_exp[9] && m_phase != 2 && m_stall != 32'hFFFF_FFFF)
                m_stall <= m_stall + 1;
            if (|m_exp[4:1] && m_flush != 32'hFFFF_FFFF)
                m_flush <= m_flush + 1;
            if (m_phase == 1) begin
                m_phase <= 2;
            end else if (m_phase == 0) begin
                if (!bus.dhit && (m_wait || bus.exmem_memread || bus.exmem_memwrite)) begin
                    m_wait <= 1'b1;
                end else begin
                    m_wait <= 1'b0;
                    if (bus.exmem_halt) m_phase <= 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        n_checks++;
        if (dut_vec !== m_exp) begin
            n_errors++;
            $display("FAIL cycle_outputs t=%0t got %b expected %b", $time, dut_vec, m_exp);
        end
`ifdef PLCTRL_PERF_EN
        n_checks++;
        if (bus.stall_cnt !== m_stall || bus.flush_cnt !== m_flush) begin
            n_errors++;
            $display("FAIL perf_counters t=%0t got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                     $time, bus.stall_cnt, bus.flush_cnt, m_stall, m_flush);
        end
`endif
    end

    // Literal expectation: checks both the DUT and the model itself.
    task automatic check_lit(input string name, input logic [9:0] exp);
        n_checks++;
        if (dut_vec !== exp) begin
            n_errors++;
            $display("FAIL %s dut got %b expected %b", name, dut_vec, exp);
        end
        n_checks++;
        if (m_exp !== exp) begin
            n_errors++;
            $display("FAIL %s_model got %b expected %b", name, m_exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ihit           = 1'b1;
        bus.dhit           = 1'b0;
        bus.exmem_memread  = 1'b0;
        bus.exmem_memwrite = 1'b0;
        bus.idex_memread   = 1'b0;
        bus.idex_rt        = '0;
        bus.ifid_rs        = '0;
        bus.ifid_rt        = '0;
        bus.branch_taken   = 1'b0;
        bus.jump           = 1'b0;
        bus.exmem_halt     = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        regbits_t r_sel;
        RST = 1'b1;
        clear_inputs();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        @(negedge CLK); check_lit("idle", C_ALL_RUN);
`ifdef PLCTRL_PERF_EN
        n_checks++;
        if (bus.stall_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL stall_cnt_idle got %0d expected 0", bus.stall_cnt);
        end
`endif
        // Load-use hazard, then the same with register 0.
        tick(); bus.idex_memread = 1'b1; bus.idex_rt = 5'd8; bus.ifid_rs = 5'd8;
        @(negedge CLK); check_lit("load_use", C_LOADUSE);
        tick(); bus.idex_rt = 5'd0; bus.ifid_rs = 5'd0; bus.ifid_rt = 5'd0;
        @(negedge CLK); check_lit("hazard_r0", C_ALL_RUN);
        // Branch beats jump and hazard.
        tick(); bus.idex_rt = 5'd8; bus.ifid_rt = 5'd8; bus.ifid_rs = 5'd3;
        bus.branch_taken = 1'b1; bus.jump = 1'b1;
        @(negedge CLK); check_lit("branch_wins", C_BRANCH);
        // Missing fetch for two cycles, then jump together with missing fetch.
        tick(); clear_inputs(); bus.ihit = 1'b0;
        @(negedge CLK); check_lit("nofetch_1", C_NOFETCH);
        tick();
        @(negedge CLK); check_lit("nofetch_2", C_NOFETCH);
        tick(); bus.jump = 1'b1;
        @(negedge CLK); check_lit("jump_over_nofetch", C_JUMP);
        // Memory wait of 3 frozen cycles, with a branch held off.
        tick(); clear_inputs(); bus.exmem_memread = 1'b1; bus.branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); check_lit("mem_freeze", C_FREEZE);
            tick();
        end
        bus.dhit = 1'b1;
        @(negedge CLK); check_lit("mem_release_branch", C_BRANCH);
        tick(); clear_inputs();
        @(negedge CLK); check_lit("after_wait", C_ALL_RUN);
        // Halt: enter, drain, stop.
        tick(); bus.exmem_halt = 1'b1;
        @(negedge CLK); check_lit("halt_enter", C_DRAIN);
        tick(); clear_inputs();
        @(negedge CLK); check_lit("halt_drain", C_DRAIN);
        tick(); bus.branch_taken = 1'b1; bus.ihit = 1'b0;
        @(negedge CLK); check_lit("halted", C_HALTED);
        tick();
        @(negedge CLK); check_lit("halted_hold", C_HALTED);
        tick(); clear_inputs(); RST = 1'b1;
        #1 check_lit("rst_from_halt", C_ALL_RUN);
        tick(); RST = 1'b0;
        // Asynchronous reset in the middle of DRAIN.
        tick(); bus.exmem_halt = 1'b1;
        tick(); clear_inputs();
        @(negedge CLK); check_lit("drain_again", C_DRAIN);
        #1 RST = 1'b1;
        #1 check_lit("rst_mid_drain", C_ALL_RUN);
        tick(); RST = 1'b0;

        // Randomized traffic checked every cycle by the compare process.
        for (int c = 0; c < 3000; c++) begin
            tick();
            RST                = ($urandom_range(99) < 2);
            bus.ihit           = ($urandom_range(99) < 80);
            bus.dhit           = ($urandom_range(99) < 45);
            bus.exmem_memread  = ($urandom_range(99) < 20);
            bus.exmem_memwrite = ($urandom_range(99) < 10);
            bus.idex_memread   = ($urandom_range(99) < 35);
            r_sel = regbits_t'($urandom_range(3)); bus.idex_rt = r_sel;
            r_sel = regbits_t'($urandom_range(3)); bus.ifid_rs = r_sel;
            r_sel = regbits_t'($urandom_range(3)); bus.ifid_rt = r_sel;
            bus.branch_taken   = ($urandom_range(99) < 15);
            bus.jump           = ($urandom_range(99) < 15);
            bus.exmem_halt     = ($urandom_range(99) < 3);
        end
        tick(); RST = 1'b0; clear_inputs();
        @(negedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
